// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Purpose:
//   Raster timing generator for a VGA-style display. Walks a pixel position
//   (hcount, vcount) across a frame of H_TOTAL x V_TOTAL positions and
//   produces sync pulses, blanking flags, data enable and line/frame strobes.
//   Every output is a flop, and every flag is computed from the same next
//   position that loads the counters. As a result, each flag always describes
//   the hcount/vcount value shown in the same cycle.
//
// Ports:
//   pclk         in   pixel clock, all state updates on the rising edge
//   rst_n        in   asynchronous active-low reset
//   ce           in   pixel advance enable; nothing moves while low
//   hcount       out  current pixel position within the line   [CNT_W]
//   vcount       out  current line position within the frame   [CNT_W]
//   hsync/vsync  out  sync pulses, active level set by HS_POL / VS_POL
//   hblnk/vblnk  out  blanking flags, active-high
//   de           out  data enable, high only inside the visible area
//   line_start   out  one-cycle strobe when hcount wraps to 0
//   frame_start  out  one-cycle strobe when (hcount, vcount) wraps to (0, 0)
//   frame_cnt    out  completed-frame counter, modulo 2^FC_W    [FC_W]
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module vga_timing_gen #(
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BP     = 160,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 29,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CNT_W    = 11,
    parameter int FC_W     = 8
) (
    input  logic             pclk,
    input  logic             rst_n,
    input  logic             ce,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hsync,
    output logic             vsync,
    output logic             hblnk,
    output logic             vblnk,
    output logic             de,
    output logic             line_start,
    output logic             frame_start,
    output logic [FC_W-1:0]  frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int CW1     = CNT_W + 1;

    // Counter positions 0 .. TOTAL-1 must be representable in CNT_W bits.
    generate
        if (H_TOTAL > (2 ** CNT_W)) begin : g_h_total_too_wide
            $error("vga_timing_gen: H_TOTAL does not fit in CNT_W bits");
        end
        if (V_TOTAL > (2 ** CNT_W)) begin : g_v_total_too_wide
            $error("vga_timing_gen: V_TOTAL does not fit in CNT_W bits");
        end
    endgenerate

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    // Region bounds are held one bit wider than the counters. The end of a
    // sync pulse may sit exactly at 2^CNT_W when the back porch is zero.
    localparam logic [CNT_W:0] H_ACT_B = CW1'(H_ACTIVE);
    localparam logic [CNT_W:0] HS_BEG  = CW1'(H_ACTIVE + H_FP);
    localparam logic [CNT_W:0] HS_END  = CW1'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W:0] V_ACT_B = CW1'(V_ACTIVE);
    localparam logic [CNT_W:0] VS_BEG  = CW1'(V_ACTIVE + V_FP);
    localparam logic [CNT_W:0] VS_END  = CW1'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] hcount_q, hcount_d;
    logic [CNT_W-1:0] vcount_q, vcount_d;
    logic [FC_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             hblnk_q, hblnk_d;
    logic             vblnk_q, vblnk_d;
    logic             de_q, de_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;

    logic             h_wrap;
    logic             v_wrap;
    logic [CNT_W:0]   h_nxt_w;
    logic [CNT_W:0]   v_nxt_w;

    assign h_wrap = (hcount_q == H_LAST);
    assign v_wrap = (vcount_q == V_LAST);

    // Position and strobes.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves one unassigned and no latch can be inferred.
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        frame_cnt_d   = frame_cnt_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;

        if (ce) begin
            hcount_d = h_wrap ? '0 : hcount_q + 1'b1;
            if (h_wrap) begin
                vcount_d = v_wrap ? '0 : vcount_q + 1'b1;
            end
            line_start_d  = h_wrap;
            frame_start_d = h_wrap && v_wrap;
            if (frame_start_d) begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    // Flags are decoded from the next position, not the current one. That
    // way they land in the same cycle as the counter value they describe.
    // While ce is low the position holds, so the flags hold with it. vcount
    // only moves when hcount goes to 0, so vsync can only change then too.
    always_comb begin
        h_nxt_w = {1'b0, hcount_d};
        v_nxt_w = {1'b0, vcount_d};
        hblnk_d = (h_nxt_w >= H_ACT_B);
        vblnk_d = (v_nxt_w >= V_ACT_B);
        de_d    = !hblnk_d && !vblnk_d;
        hsync_d = ((h_nxt_w >= HS_BEG) && (h_nxt_w < HS_END)) ? HS_POL : ~HS_POL;
        vsync_d = ((v_nxt_w >= VS_BEG) && (v_nxt_w < VS_END)) ? VS_POL : ~VS_POL;
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, whatever order the statements are in.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            frame_cnt_q   <= '0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            hblnk_q       <= 1'b0;
            vblnk_q       <= 1'b0;
            de_q          <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            frame_cnt_q   <= frame_cnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            hblnk_q       <= hblnk_d;
            vblnk_q       <= vblnk_d;
            de_q          <= de_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign frame_cnt   = frame_cnt_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign hblnk       = hblnk_q;
    assign vblnk       = vblnk_q;
    assign de          = de_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Drives three instances of vga_timing_gen:
//   dut 0 (def)   : default 1024x768 timing, active-low syncs
//   dut 1 (small) : 8/2/2/2 x 4/1/1/1 timing, CNT_W=4, FC_W=2
//   dut 2 (pol)   : small timing with active-high syncs
// Each instance is compared against a reference model every cycle. The model
// derives the raster position from the number of enabled cycles since reset.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_vga_timing_gen;

    typedef struct packed {
        logic [15:0] h;
        logic [15:0] v;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic        de;
        logic        ls;
        logic        fs;
        logic [7:0]  fc;
    } out_t;

    typedef struct {
        int ha, hfp, hsw, hbp;
        int va, vfp, vsw, vbp;
        bit hpol, vpol;
        int fcw;
    } cfg_t;

    typedef struct {
        bit   ce;
        int   cycles;
        out_t exp;
    } vec_t;

    logic       pclk = 1'b0;
    logic       rst_n;
    logic [2:0] ce_v;

    always #5 pclk = ~pclk;

    logic [10:0] hc0, vc0;
    logic [3:0]  hc1, vc1;
    logic [4:0]  hc2, vc2;
    logic        hs0, vs0, hb0, vb0, de0, ls0, fs0;
    logic        hs1, vs1, hb1, vb1, de1, ls1, fs1;
    logic        hs2, vs2, hb2, vb2, de2, ls2, fs2;
    logic [7:0]  fc0;
    logic [1:0]  fc1;
    logic [7:0]  fc2;

    vga_timing_gen u_def (
        .pclk(pclk), .rst_n(rst_n), .ce(ce_v[0]),
        .hcount(hc0), .vcount(vc0), .hsync(hs0), .vsync(vs0),
        .hblnk(hb0), .vblnk(vb0), .de(de0),
        .line_start(ls0), .frame_start(fs0), .frame_cnt(fc0)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CNT_W(4), .FC_W(2)
    ) u_small (
        .pclk(pclk), .rst_n(rst_n), .ce(ce_v[1]),
        .hcount(hc1), .vcount(vc1), .hsync(hs1), .vsync(vs1),
        .hblnk(hb1), .vblnk(vb1), .de(de1),
        .line_start(ls1), .frame_start(fs1), .frame_cnt(fc1)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(5), .FC_W(8)
    ) u_pol (
        .pclk(pclk), .rst_n(rst_n), .ce(ce_v[2]),
        .hcount(hc2), .vcount(vc2), .hsync(hs2), .vsync(vs2),
        .hblnk(hb2), .vblnk(vb2), .de(de2),
        .line_start(ls2), .frame_start(fs2), .frame_cnt(fc2)
    );

    function automatic out_t mk(input int h, input int v, input logic hs, input logic vs,
                                input logic hb, input logic vb, input logic de,
                                input logic ls, input logic fs, input int fc);
        out_t o;
        o.h  = 16'(h);
        o.v  = 16'(v);
        o.hs = hs;
        o.vs = vs;
        o.hb = hb;
        o.vb = vb;
        o.de = de;
        o.ls = ls;
        o.fs = fs;
        o.fc = 8'(fc);
        return o;
    endfunction

    out_t act [3];
    assign act[0] = mk(int'(hc0), int'(vc0), hs0, vs0, hb0, vb0, de0, ls0, fs0, int'(fc0));
    assign act[1] = mk(int'(hc1), int'(vc1), hs1, vs1, hb1, vb1, de1, ls1, fs1, int'(fc1));
    assign act[2] = mk(int'(hc2), int'(vc2), hs2, vs2, hb2, vb2, de2, ls2, fs2, int'(fc2));

    // Reference model. n is the number of enabled cycles since reset, and
    // lc says whether the most recent clock edge was an enabled one.
    function automatic out_t model(input cfg_t c, input int n, input bit lc);
        int   ht, vt, h, line, v, frames;
        out_t e;
        ht     = c.ha + c.hfp + c.hsw + c.hbp;
        vt     = c.va + c.vfp + c.vsw + c.vbp;
        h      = n % ht;
        line   = n / ht;
        v      = line % vt;
        frames = line / vt;
        e.h  = 16'(h);
        e.v  = 16'(v);
        e.hb = (h >= c.ha);
        e.vb = (v >= c.va);
        e.de = !e.hb && !e.vb;
        e.hs = (h >= c.ha + c.hfp && h < c.ha + c.hfp + c.hsw) ? c.hpol : !c.hpol;
        e.vs = (v >= c.va + c.vfp && v < c.va + c.vfp + c.vsw) ? c.vpol : !c.vpol;
        e.ls = lc && (h == 0);
        e.fs = e.ls && (v == 0);
        e.fc = 8'(frames % (1 << c.fcw));
        return e;
    endfunction

    int     vectors    = 0;
    int     miscompares = 0;
    cfg_t   cfg [3];
    int     n_ce [3];
    bit     last_ce [3];
    string  dut_name [3];
    int     fs_log [5];
    int     fs_seen = 0;

    task automatic check(input string name, input out_t a, input out_t e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s @%0t: got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b de=%b ls=%b fs=%b fc=%0d, expected h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b de=%b ls=%b fs=%b fc=%0d",
                     name, $time, a.h, a.v, a.hs, a.vs, a.hb, a.vb, a.de, a.ls, a.fs, a.fc,
                     e.h, e.v, e.hs, e.vs, e.hb, e.vb, e.de, e.ls, e.fs, e.fc);
        end
    endtask

    task automatic check_int(input string name, input int a, input int e);
        vectors++;
        if (a != e) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, a, e);
        end
    endtask

    task automatic reset_models();
        for (int i = 0; i < 3; i++) begin
            n_ce[i]    = 0;
            last_ce[i] = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_%s", tag, dut_name[i]), act[i],
                  model(cfg[i], n_ce[i], last_ce[i]));
        end
    endtask

    // One clock: advance the models with the enables seen at the edge, then
    // compare all three instances 1 ns after the edge.
    task automatic step();
        @(posedge pclk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (rst_n) begin
                n_ce[i]    = n_ce[i] + int'(ce_v[i]);
                last_ce[i] = ce_v[i];
            end else begin
                n_ce[i]    = 0;
                last_ce[i] = 1'b0;
            end
        end
        check_all("cyc");
        if (act[1].fs === 1'b1) begin
            if (fs_seen < 5) fs_log[fs_seen] = int'(act[1].fc);
            fs_seen++;
        end
    endtask

    vec_t tbl [16];
    bit   pat [4];
    int   fc_exp [5];

    initial begin
        bit found;

        cfg[0] = '{ha: 1024, hfp: 24, hsw: 136, hbp: 160, va: 768, vfp: 3, vsw: 6, vbp: 29,
                   hpol: 1'b0, vpol: 1'b0, fcw: 8};
        cfg[1] = '{ha: 8, hfp: 2, hsw: 2, hbp: 2, va: 4, vfp: 1, vsw: 1, vbp: 1,
                   hpol: 1'b0, vpol: 1'b0, fcw: 2};
        cfg[2] = '{ha: 8, hfp: 2, hsw: 2, hbp: 2, va: 4, vfp: 1, vsw: 1, vbp: 1,
                   hpol: 1'b1, vpol: 1'b1, fcw: 8};
        dut_name[0] = "def";
        dut_name[1] = "small";
        dut_name[2] = "pol";

        // Hand-derived walk of the active-high instance from reset.
        //                 ce    n   h   v  hs vs hb vb de ls fs fc
        tbl[0]  = '{1'b1,  1, mk( 1, 0, 0, 0, 0, 0, 1, 0, 0, 0)};
        tbl[1]  = '{1'b0,  3, mk( 1, 0, 0, 0, 0, 0, 1, 0, 0, 0)};
        tbl[2]  = '{1'b1,  6, mk( 7, 0, 0, 0, 0, 0, 1, 0, 0, 0)};
        tbl[3]  = '{1'b1,  1, mk( 8, 0, 0, 0, 1, 0, 0, 0, 0, 0)};
        tbl[4]  = '{1'b1,  2, mk(10, 0, 1, 0, 1, 0, 0, 0, 0, 0)};
        tbl[5]  = '{1'b1,  1, mk(11, 0, 1, 0, 1, 0, 0, 0, 0, 0)};
        tbl[6]  = '{1'b1,  1, mk(12, 0, 0, 0, 1, 0, 0, 0, 0, 0)};
        tbl[7]  = '{1'b1,  2, mk( 0, 1, 0, 0, 0, 0, 1, 1, 0, 0)};
        tbl[8]  = '{1'b0,  1, mk( 0, 1, 0, 0, 0, 0, 1, 0, 0, 0)};
        tbl[9]  = '{1'b1, 28, mk( 0, 3, 0, 0, 0, 0, 1, 1, 0, 0)};
        tbl[10] = '{1'b1, 14, mk( 0, 4, 0, 0, 0, 1, 0, 1, 0, 0)};
        tbl[11] = '{1'b1, 14, mk( 0, 5, 0, 1, 0, 1, 0, 1, 0, 0)};
        tbl[12] = '{1'b1, 14, mk( 0, 6, 0, 0, 0, 1, 0, 1, 0, 0)};
        tbl[13] = '{1'b1, 13, mk(13, 6, 0, 0, 1, 1, 0, 0, 0, 0)};
        tbl[14] = '{1'b1,  1, mk( 0, 0, 0, 0, 0, 0, 1, 1, 1, 1)};
        tbl[15] = '{1'b1,  1, mk( 1, 0, 0, 0, 0, 0, 1, 0, 0, 1)};

        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        fc_exp[0] = 1; fc_exp[1] = 2; fc_exp[2] = 3; fc_exp[3] = 0; fc_exp[4] = 1;

        // Reset: the values must appear before any clock edge.
        ce_v  = 3'b000;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        reset_models();
        check_all("rst_async");
        check("rst_pol_idle_low", act[2], mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        check("rst_def_idle_high", act[0], mk(0, 0, 1, 1, 0, 0, 1, 0, 0, 0));
        ce_v = 3'b111;
        step();
        #1 rst_n = 1'b1;

        // Table walk. The other instances keep running and are checked by the model.
        for (int t = 0; t < 16; t++) begin
            ce_v = {tbl[t].ce, 1'b1, 1'b1};
            repeat (tbl[t].cycles) step();
            check($sformatf("table%0d", t), act[2], tbl[t].exp);
        end

        // Random enables. The small instance first sees the 1,0,0,1 pattern.
        for (int i = 0; i < 2000; i++) begin
            ce_v[0] = ($urandom_range(0, 7) != 0);
            ce_v[1] = (i < 400) ? pat[i % 4] : 1'($urandom_range(0, 1));
            ce_v[2] = 1'($urandom_range(0, 1));
            step();
        end

        for (int j = 0; j < 5; j++) begin
            check_int($sformatf("fc_seq%0d", j), (fs_seen > j) ? fs_log[j] : -1, fc_exp[j]);
        end

        // Reset mid-frame at (5,3) on the small instance.
        ce_v  = 3'b111;
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            if (act[1].h == 16'd5 && act[1].v == 16'd3) found = 1'b1;
            else step();
        end
        check_int("reach_5_3", int'(found), 1);
        #3 rst_n = 1'b0;
        #1;
        reset_models();
        check_all("rst_mid");
        step();
        rst_n = 1'b1;
        step();
        check("restart_h1", act[1], mk(1, 0, 1, 1, 0, 0, 1, 0, 0, 0));
        repeat (120) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1024, visible pixels per line.
REQ-002 SHALL have parameters H_FP, H_SYNC, H_BP, defaults 24, 136, 160, horizontal front porch, sync width and back porch in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 768, visible lines per frame.
REQ-004 SHALL have parameters V_FP, V_SYNC, V_BP, defaults 3, 6, 29, vertical front porch, sync width and back porch in lines.
REQ-005 SHALL have parameters HS_POL and VS_POL, default 0 each, sync active level (0 = active-low, 1 = active-high).
REQ-006 SHALL have parameter CNT_W, default 11, counter width, and FC_W, default 8, frame counter width.
REQ-007 pclk  input  1  pixel clock; all state on rising edge.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 ce  input  1  pixel advance enable; counters step only when ce=1.
REQ-010 hcount, vcount  output  CNT_W each  current pixel and line position.
REQ-011 hsync, vsync  output  1 each  sync pulses at parameterised polarity.
REQ-012 hblnk, vblnk  output  1 each  blanking flags, active-high.
REQ-013 de  output  1  data enable, high only in the active area.
REQ-014 line_start, frame_start  output  1 each  single-cycle strobes.
REQ-015 frame_cnt  output  FC_W  completed-frame counter.

Function
REQ-016 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP; both SHALL fit in CNT_W bits, or elaboration SHALL fail.
REQ-017 With ce=1, hcount SHALL increment by 1 per pclk and wrap from H_TOTAL-1 to 0.
REQ-018 vcount SHALL increment only on the cycle hcount wraps, and SHALL wrap from V_TOTAL-1 to 0 on that same cycle.
REQ-019 With ce=0, every output SHALL hold its value, and line_start/frame_start SHALL be 0.
REQ-020 All outputs SHALL be registered and mutually consistent, i.e. every flag SHALL describe the hcount/vcount value shown in the same cycle (zero skew).
REQ-021 hblnk SHALL be 1 iff hcount >= H_ACTIVE; vblnk SHALL be 1 iff vcount >= V_ACTIVE; de SHALL equal !hblnk && !vblnk.
REQ-022 hsync SHALL be at HS_POL iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC, otherwise at !HS_POL.
REQ-023 vsync SHALL be at VS_POL iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC, otherwise at !VS_POL; vsync SHALL change only when hcount changes to 0.
REQ-024 line_start SHALL be 1 for exactly one pclk, in the cycle when hcount becomes 0 by wrap.
REQ-025 frame_start SHALL be 1 for exactly one pclk, in the cycle when (hcount, vcount) becomes (0, 0) by wrap; line_start SHALL also be 1 in that cycle.
REQ-026 frame_cnt SHALL increment modulo 2^FC_W in the cycle frame_start asserts.
REQ-027 If ce toggles at any rate, the sequence of (hcount, vcount) values per ce=1 cycle SHALL be identical to free-running operation.

Reset
REQ-028 While rst_n=0, outputs SHALL be: hcount=0, vcount=0, hblnk=0, vblnk=0, de=1, hsync=!HS_POL, vsync=!VS_POL, line_start=0, frame_start=0, frame_cnt=0.
REQ-029 Assertion of rst_n SHALL take effect immediately, mid-line or mid-frame.
REQ-030 The first ce=1 cycle after deassertion SHALL move hcount to 1; line_start and frame_start SHALL NOT pulse for the reset-origin position.

Verification
REQ-031 Defaults, ce=1 for 2 frames -> hsync low for hcount 1048..1183, vsync low for vcount 771..776, frame_start every 1344*806 = 1083264 cycles, frame_cnt=2.
REQ-032 H 8/2/2/2, V 4/1/1/1, ce=1 -> hcount period 14, vcount period 7, de high in 32 of 98 cycles per frame.
REQ-033 HS_POL=1, VS_POL=1 -> sync pulses active-high, idle low directly after reset.
REQ-034 ce pattern 1,0,0,1 repeated -> count sequence matches free-run at ce=1 samples, no strobes while ce=0.
REQ-035 rst_n pulsed low at hcount=5, vcount=3 -> all outputs return to the REQ-028 values asynchronously; restart from (0,0) with frame_cnt=0.
REQ-036 FC_W=2, run 5 frames -> frame_cnt sequence 1,2,3,0,1.
